// File: rtl/morty_pkg.sv
// Shared Morty pipeline definitions: fetch exception causes, the NOP filler
// word, the fetch-state encoding and the IF/ID entry layout.
package morty_pkg;

    localparam logic [3:0]  EXC_INST_MISALIGNED = 4'd0;
    localparam logic [3:0]  EXC_INST_ACCESS     = 4'd1;
    localparam logic [31:0] NOP_INST            = 32'h0000_0033;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_FLUSH,
        ST_HALT
    } fetch_state_e;

    // One presented entry of the IF/ID register.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [3:0]  cause;
        logic        trap;
        logic [31:0] tval;
    } fetch_entry_t;

    // An empty entry: ID sees a NOP with no exception attached.
    function automatic fetch_entry_t nop_entry();
        return '{pc: 32'h0, inst: NOP_INST, cause: 4'd0, trap: 1'b0, tval: 32'h0};
    endfunction

    // Exception entry: faulting PC doubles as mtval.
    function automatic fetch_entry_t exc_entry(logic [31:0] pc, logic [3:0] cause);
        return '{pc: pc, inst: NOP_INST, cause: cause, trap: 1'b1, tval: pc};
    endfunction

endpackage

// File: rtl/morty_if_stage_if.sv
// Instruction-memory bus, Wishbone-classic style (req = cyc & stb).
interface morty_if_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        imem_err;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_err, imem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_err, imem_rdata
    );
endinterface

// File: rtl/morty_if_stage.sv
// Morty RV32 instruction-fetch stage: owns the PC, runs one instruction
// memory read at a time and holds a single-entry output buffer for ID.
module morty_if_stage
    import morty_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0200
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    id_stall,
    input  logic                    ex_branch_valid,
    input  logic [31:0]             ex_branch_target,
    input  logic                    trap_redirect_valid,
    input  logic [31:0]             trap_redirect_pc,
    morty_if_stage_if.master        imem,
    output logic                    if_valid,
    output logic [31:0]             if_pc,
    output logic [31:0]             if_inst,
    output logic [3:0]              if_exception,
    output logic                    if_trap_valid,
    output logic [31:0]             if_exc_data
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  tgt_q, tgt_d;
    logic         vld_q, vld_d;
    fetch_entry_t buf_q, buf_d;

    logic         redir;
    logic [31:0]  redir_pc;
    logic         consume;

    // Trap/mret redirects outrank EX branches.
    assign redir    = trap_redirect_valid | ex_branch_valid;
    assign redir_pc = trap_redirect_valid ? trap_redirect_pc : ex_branch_target;
    assign consume  = vld_q & ~id_stall;

    // Bus request is a pure decode of registered state.
    assign imem.imem_req  = (state_q == ST_REQ) || (state_q == ST_FLUSH);
    assign imem.imem_addr = pc_q;

    assign if_valid      = vld_q;
    assign if_pc         = buf_q.pc;
    assign if_inst       = buf_q.inst;
    assign if_exception  = buf_q.cause;
    assign if_trap_valid = buf_q.trap;
    assign if_exc_data   = buf_q.tval;

    // Next-state, PC and output-buffer update.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        vld_d   = vld_q;
        buf_d   = buf_q;

        // ID takes the entry: leave a NOP behind, keep the PC for debug.
        if (consume) begin
            vld_d      = 1'b0;
            buf_d.inst = NOP_INST;
            buf_d.trap = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (!vld_q || consume) begin
                    if (pc_q[1:0] == 2'b00) begin
                        state_d = ST_REQ;
                    end else begin
                        vld_d   = 1'b1;
                        buf_d   = exc_entry(pc_q, EXC_INST_MISALIGNED);
                        state_d = ST_HALT;
                    end
                end
            end
            ST_REQ: begin
                if (imem.imem_ack) begin
                    vld_d = 1'b1;
                    if (imem.imem_err) begin
                        buf_d   = exc_entry(pc_q, EXC_INST_ACCESS);
                        state_d = ST_HALT;
                    end else begin
                        buf_d      = nop_entry();
                        buf_d.pc   = pc_q;
                        buf_d.inst = imem.imem_rdata;
                        pc_d       = pc_q + 32'd4;
                        state_d    = ST_IDLE;
                    end
                end
            end
            ST_FLUSH: begin
                // Stale data is dropped; resume at the saved target.
                if (imem.imem_ack) begin
                    pc_d    = tgt_q;
                    state_d = ST_IDLE;
                end
            end
            ST_HALT: begin
                // Wait here for a redirect.
            end
            default: state_d = ST_IDLE;
        endcase

        // A redirect kills whatever is buffered and retargets the PC. An
        // open bus cycle cannot be abandoned, so it is drained via FLUSH.
        if (redir) begin
            vld_d      = 1'b0;
            buf_d.inst = NOP_INST;
            buf_d.trap = 1'b0;
            if ((state_q == ST_REQ || state_q == ST_FLUSH) && !imem.imem_ack) begin
                tgt_d   = redir_pc;
                state_d = ST_FLUSH;
            end else begin
                pc_d    = redir_pc;
                state_d = ST_IDLE;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_ADDR;
            tgt_q   <= 32'h0;
            vld_q   <= 1'b0;
            buf_q   <= nop_entry();
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            vld_q   <= vld_d;
            buf_q   <= buf_d;
        end
    end

endmodule

// File: doc/morty_if_stage.md
# morty_if_stage

Instruction-fetch stage of the Morty RV32 pipeline. It owns the program counter, issues Wishbone-classic-style reads to instruction memory, and presents one fetched instruction, its PC and any fetch exception to the IF/ID pipeline register. It follows redirects from EX (branch/jump) and from the trap/CSR unit (trap entry, mret). When it has nothing valid to present, it signals the hazard unit so that ID receives a bubble.

## Interface
- RESET_ADDR, 32'h0000_0200, first fetch address after reset
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  synchronous, active-low reset
- id_stall  in  1  downstream cannot accept; the presented instruction is held
- ex_branch_valid  in  1  EX redirect request
- ex_branch_target  in  32  EX redirect address
- trap_redirect_valid  in  1  trap/mret redirect request; outranks EX
- trap_redirect_pc  in  32  trap/mret redirect address
- imem_req  out  1  bus cycle active (cyc&stb)
- imem_addr  out  32  fetch address; word aligned
- imem_ack  in  1  read complete; may assert in the same cycle as imem_req
- imem_err  in  1  access error; qualified by imem_ack
- imem_rdata  in  32  instruction word; qualified by imem_ack
- if_valid  out  1  outputs below are meaningful; the hazard unit drives id_bubble = !if_valid
- if_pc  out  32  PC of the presented instruction
- if_inst  out  32  instruction; 32'h33 when there is none or on an exception
- if_exception  out  4  cause: 4'd0 misaligned fetch, 4'd1 access fault
- if_trap_valid  out  1  presented entry carries an exception
- if_exc_data  out  32  faulting address (mtval)

## Operation
- Output buffer: one entry. It is consumed at an edge where if_valid=1 and id_stall=0.
- States:
  - IDLE
    - Moves to REQ when the buffer is empty or is being consumed this cycle, and pc[1:0]==0.
    - If pc[1:0]!=0, no bus request is made. The stage loads the buffer with: if_trap_valid=1, cause 0, if_exc_data=pc, if_inst=32'h33, if_pc=pc. It then moves to HALT.
  - REQ
    - imem_req=1 and imem_addr=pc; both are held stable until ack.
    - On ack with no error: buffer gets {pc, rdata}, pc<=pc+4, state goes to IDLE.
    - On ack with error: buffer gets the access-fault entry (cause 1, if_exc_data=pc). State goes to HALT.
  - FLUSH
    - A redirect arrived mid-cycle. imem_req is held until ack, the returned data is discarded, then pc<=saved target and state goes to IDLE.
  - HALT
    - No fetching. The exception entry is held until it is consumed, then if_valid=0.
    - The stage stays in HALT until any redirect arrives.
- Redirects, in any state:
  - The buffer is invalidated at that edge (if_valid<=0, if_inst<=32'h33, if_trap_valid<=0).
  - The target is trap_redirect_pc when trap_redirect_valid=1, otherwise ex_branch_target.
  - From REQ without ack in the same cycle: save the target and go to FLUSH.
  - From REQ with ack in the same cycle: discard the data, pc<=target, go to IDLE.
  - From IDLE or HALT: pc<=target, go to IDLE.
  - In FLUSH: a newer redirect overwrites the saved target (trap priority still applies).

## Timing
- Reset (rst=0 at an edge):
  - pc=RESET_ADDR, state IDLE, imem_req=0.
  - if_valid=0, if_pc=0, if_inst=32'h33, if_exception=0, if_trap_valid=0, if_exc_data=0.
- imem_req is a decode of registered state; it carries no combinational path from id_stall.
- Zero-wait memory: request in cycle N, ack in N, if_valid=1 from N+1. Peak throughput is one instruction every 2 cycles.
- Redirect sampled at edge E: the first request to the target appears at E+1 if no bus cycle is open. Otherwise it appears one cycle after the pending ack.
- Reset asserted mid-bus-cycle: imem_req drops at the next edge. The memory must tolerate an aborted cycle.
- The buffer contents never change while if_valid=1 and id_stall=1.

## Structure
- A shared package morty_pkg holds:
  - exception cause constants EXC_INST_MISALIGNED=4'd0 and EXC_INST_ACCESS=4'd1
  - NOP_INST=32'h33
  - the fetch-state enum
- Single module, no sub-modules. The redirect mux and priority are written inline.

## Test plan
- Reset release, zero-wait memory returning 32'h00500093: imem_addr=32'h200 in the first REQ cycle; if_pc=32'h200, if_inst=32'h00500093, if_valid=1 one cycle later.
- id_stall held 3 cycles with the buffer full: no new imem_req, and if_pc/if_inst stay unchanged. Fetch of 32'h204 starts at the edge where id_stall falls.
- ex_branch_valid=1 (target 32'h400) while a REQ is waiting 2 cycles for ack:
  - imem_req stays high until ack and the data is dropped
  - next imem_addr=32'h400
  - if_valid is 0 throughout
- trap_redirect_valid=1 (32'h100) and ex_branch_valid=1 (32'h400) in the same cycle: next fetch is 32'h100.
- Branch target 32'h402: no bus request; if_trap_valid=1, if_exception=0, if_exc_data=32'h402, if_inst=32'h33. The stage halts until a trap redirect to 32'h100, then resumes at 32'h100.
- imem_err with ack at 32'h208: if_exception=1, if_exc_data=32'h208. No further requests until a redirect.
